// File: rtl/lock_keygate_array.sv
// Key-gated datapath: a serially loaded key drives XOR gates on the data bits
// and 4:1 mux gates; too many key reloads latch the block into lockout.
module lock_keygate_array #(
  parameter int DATA_W     = 8,
  parameter int LUT_N      = 1,
  parameter int MAX_RELOAD = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_start,
  input  logic              key_valid,
  input  logic              key_bit,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LUT_N-1:0]  in_lut_a,
  input  logic [LUT_N-1:0]  in_lut_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [LUT_N-1:0]  out_lut,
  output logic              armed,
  output logic              key_ready,
  output logic              locked_out
);

  localparam int KEY_W  = DATA_W + 4*LUT_N;
  localparam int CNT_W  = $clog2(KEY_W + 1);
  localparam int LCNT_W = (MAX_RELOAD < 1) ? 1 : $clog2(MAX_RELOAD + 1);

  typedef enum logic [1:0] {EMPTY, LOADING, ARMED, LOCKOUT} state_t;

  state_t            state, state_next;
  logic [KEY_W-1:0]  key;
  logic [CNT_W-1:0]  bit_cnt;
  logic [LCNT_W-1:0] load_cnt;
  logic              start_ok, start_lock, shift_en, last_bit, sample;
  logic [LUT_N-1:0]  lut_next;

  // key_start outranks key_valid and in_valid in the same cycle
  always_comb begin
    start_ok   = key_start && (state != LOCKOUT) && (load_cnt <  LCNT_W'(MAX_RELOAD));
    start_lock = key_start && (state != LOCKOUT) && (load_cnt >= LCNT_W'(MAX_RELOAD));
    shift_en   = (state == LOADING) && key_valid && !key_start;
    last_bit   = (bit_cnt == CNT_W'(KEY_W - 1));
    sample     = in_valid && (state == ARMED) && !key_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_lock)              state_next = LOCKOUT;
    else if (start_ok)           state_next = LOADING;
    else if (shift_en && last_bit) state_next = ARMED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key      <= '0;
      bit_cnt  <= '0;
      load_cnt <= '0;
    end else if (start_ok) begin
      key      <= '0;
      bit_cnt  <= '0;
      load_cnt <= load_cnt + LCNT_W'(1);
    end else if (start_lock) begin
      key      <= '0;
    end else if (shift_en) begin
      key      <= {key[KEY_W-2:0], key_bit};
      bit_cnt  <= bit_cnt + CNT_W'(1);
    end
  end

  // Each mux gate owns a 4-entry truth table in the key above the XOR bits
  always_comb begin
    logic [3:0] p;
    p        = '0;
    lut_next = '0;
    for (int j = 0; j < LUT_N; j++) begin
      p           = key[DATA_W + 4*j +: 4];
      lut_next[j] = p[{in_lut_b[j], in_lut_a[j]}];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lut   <= '0;
    end else begin
      out_valid <= sample;
      if (sample) begin
        out_data <= in_data ^ key[DATA_W-1:0];
        out_lut  <= lut_next;
      end
    end
  end

  assign armed      = (state == ARMED);
  assign locked_out = (state == LOCKOUT);
  assign key_ready  = (state == EMPTY) || (state == LOADING);

endmodule

// File: tb/tb_lock_keygate_array.sv
// Scoreboard bench for lock_keygate_array: expected outputs are queued when a
// sample is driven and popped by a monitor whenever out_valid is seen.
module tb_lock_keygate_array;
  localparam int DATA_W     = 8;
  localparam int LUT_N      = 1;
  localparam int MAX_RELOAD = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              key_start = 1'b0, key_valid = 1'b0, key_bit = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [LUT_N-1:0]  in_lut_a = '0, in_lut_b = '0;
  logic              out_valid, armed, key_ready, locked_out;
  logic [DATA_W-1:0] out_data;
  logic [LUT_N-1:0]  out_lut;

  int          errors = 0;
  int          checks = 0;
  logic [8:0]  exp_q[$];
  logic [8:0]  mon_exp;
  logic [11:0] model_key = '0;
  logic [7:0]  last_data = '0;

  lock_keygate_array #(.DATA_W(DATA_W), .LUT_N(LUT_N), .MAX_RELOAD(MAX_RELOAD)) dut (
    .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_valid(key_valid),
    .key_bit(key_bit), .in_valid(in_valid), .in_data(in_data),
    .in_lut_a(in_lut_a), .in_lut_b(in_lut_b), .out_valid(out_valid),
    .out_data(out_data), .out_lut(out_lut), .armed(armed),
    .key_ready(key_ready), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  // Any out_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_out: out_valid=1 data=%h lut=%b, required no output", out_data, out_lut);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_lut, out_data} !== mon_exp) begin
          errors++;
          $display("[TB] FAIL out_check: got lut=%b data=%h, required lut=%b data=%h",
                   out_lut, out_data, mon_exp[8], mon_exp[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    key_start = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
    in_valid = 1'b0; in_data = '0; in_lut_a = '0; in_lut_b = '0;
    exp_q.delete();
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic start_pulse(input logic with_bit);
    key_start = 1'b1; key_valid = with_bit; key_bit = 1'b1;
    tick;
    key_start = 1'b0; key_valid = 1'b0;
  endtask

  task automatic shift_bits(input logic [11:0] k, input int from, input int n);
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_bit   = k[11 - from - i];
      tick;
    end
    key_valid = 1'b0;
  endtask

  task automatic sample_data(input logic [7:0] d, input logic a, input logic b, input bit expect_out);
    int idx;
    idx = DATA_W + 2*int'(b) + int'(a);
    in_valid = 1'b1; in_data = d; in_lut_a = a; in_lut_b = b;
    if (expect_out) begin
      exp_q.push_back({model_key[idx], d ^ model_key[7:0]});
      last_data = d ^ model_key[7:0];
    end
    tick;
    in_valid = 1'b0;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: %0d outputs still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks += 6;
    if (armed !== 1'b0)      begin errors++; $display("[TB] FAIL rst_armed: got %b required 0", armed); end
    if (key_ready !== 1'b1)  begin errors++; $display("[TB] FAIL rst_key_ready: got %b required 1", key_ready); end
    if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_locked: got %b required 0", locked_out); end
    if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL rst_out_valid: got %b required 0", out_valid); end
    if (out_data !== 8'h00)  begin errors++; $display("[TB] FAIL rst_out_data: got %h required 00", out_data); end
    if (out_lut !== 1'b0)    begin errors++; $display("[TB] FAIL rst_out_lut: got %b required 0", out_lut); end
    do_reset;
  endtask

  task automatic test_load_arm;
    do_reset;
    model_key = 12'hA5C;
    start_pulse(1'b0);
    shift_bits(12'hA5C, 0, 11);
    checks++;
    if (armed !== 1'b0) begin errors++; $display("[TB] FAIL arm_early: armed=%b after 11 bits, required 0", armed); end
    shift_bits(12'hA5C, 11, 1);
    checks += 2;
    if (armed !== 1'b1)     begin errors++; $display("[TB] FAIL arm_set: got %b required 1", armed); end
    if (key_ready !== 1'b0) begin errors++; $display("[TB] FAIL arm_key_ready: got %b required 0", key_ready); end
  endtask

  task automatic test_datapath;
    logic [7:0] d;
    logic a, b;
    sample_data(8'hFF, 1'b1, 1'b0, 1'b1);
    sample_data(8'hFF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      sample_data(d, a, b, 1'b1);
    end
    tick; tick;
    check_drained("datapath");
    checks += 2;
    if (out_valid !== 1'b0)     begin errors++; $display("[TB] FAIL hold_valid: got %b required 0", out_valid); end
    if (out_data !== last_data) begin errors++; $display("[TB] FAIL hold_data: got %h required %h", out_data, last_data); end
  endtask

  task automatic test_sample_gating;
    do_reset;
    model_key = 12'hA5C;
    sample_data(8'h55, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL gate_empty: out_valid=%b required 0", out_valid); end
    start_pulse(1'b0);
    sample_data(8'h55, 1'b1, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL gate_loading: out_valid=%b required 0", out_valid); end
    shift_bits(12'hA5C, 0, 12);
    key_start = 1'b1; in_valid = 1'b1; in_data = 8'h12;
    tick;
    key_start = 1'b0; in_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL gate_start: out_valid=%b required 0", out_valid); end
    if (armed !== 1'b0)     begin errors++; $display("[TB] FAIL gate_rearm: armed=%b required 0", armed); end
    if (key_ready !== 1'b1) begin errors++; $display("[TB] FAIL gate_reload: key_ready=%b required 1", key_ready); end
    tick;
    check_drained("gating");
  endtask

  task automatic test_restart;
    do_reset;
    model_key = 12'h000;
    start_pulse(1'b0);
    shift_bits(12'hFFF, 0, 5);
    start_pulse(1'b1);
    shift_bits(12'h000, 0, 11);
    checks++;
    if (armed !== 1'b0) begin errors++; $display("[TB] FAIL restart_early: armed=%b after 11 bits, required 0", armed); end
    shift_bits(12'h000, 11, 1);
    checks++;
    if (armed !== 1'b1) begin errors++; $display("[TB] FAIL restart_arm: armed=%b required 1", armed); end
    sample_data(8'h3C, 1'b1, 1'b1, 1'b1);
    tick;
    check_drained("restart");
  endtask

  task automatic test_lockout;
    do_reset;
    model_key = 12'h000;
    start_pulse(1'b0); start_pulse(1'b0); start_pulse(1'b0);
    checks += 2;
    if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL lock_early: got %b required 0", locked_out); end
    if (key_ready !== 1'b1)  begin errors++; $display("[TB] FAIL lock_ready3: got %b required 1", key_ready); end
    start_pulse(1'b0);
    checks += 3;
    if (locked_out !== 1'b1) begin errors++; $display("[TB] FAIL lock_set: got %b required 1", locked_out); end
    if (armed !== 1'b0)      begin errors++; $display("[TB] FAIL lock_armed: got %b required 0", armed); end
    if (key_ready !== 1'b0)  begin errors++; $display("[TB] FAIL lock_ready: got %b required 0", key_ready); end
    for (int i = 0; i < 14; i++) begin
      key_start = (i % 3 == 0); key_valid = 1'b1; key_bit = 1'b1;
      in_valid = 1'b1; in_data = 8'(i);
      tick;
    end
    key_start = 1'b0; key_valid = 1'b0; in_valid = 1'b0;
    checks += 2;
    if (locked_out !== 1'b1) begin errors++; $display("[TB] FAIL lock_hold: got %b required 1", locked_out); end
    if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL lock_out_valid: got %b required 0", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL lock_clear: got %b required 0", locked_out); end
    do_reset;
  endtask

  task automatic test_midload_reset;
    do_reset;
    model_key = 12'hA5C;
    start_pulse(1'b0);
    shift_bits(12'hA5C, 0, 12);
    sample_data(8'hFF, 1'b1, 1'b0, 1'b1);
    tick;
    start_pulse(1'b0);
    shift_bits(12'hA5C, 0, 7);
    #2 rst_n = 1'b0;
    #1;
    checks += 6;
    if (out_data !== 8'h00)  begin errors++; $display("[TB] FAIL mid_data: got %h required 00", out_data); end
    if (out_lut !== 1'b0)    begin errors++; $display("[TB] FAIL mid_lut: got %b required 0", out_lut); end
    if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL mid_valid: got %b required 0", out_valid); end
    if (armed !== 1'b0)      begin errors++; $display("[TB] FAIL mid_armed: got %b required 0", armed); end
    if (key_ready !== 1'b1)  begin errors++; $display("[TB] FAIL mid_ready: got %b required 1", key_ready); end
    if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_locked: got %b required 0", locked_out); end
    tick;
    rst_n = 1'b1;
    tick;
    start_pulse(1'b0); start_pulse(1'b0); start_pulse(1'b0);
    checks += 2;
    if (locked_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_credit: locked_out=%b required 0", locked_out); end
    if (key_ready !== 1'b1)  begin errors++; $display("[TB] FAIL mid_credit_ready: got %b required 1", key_ready); end
    shift_bits(12'hA5C, 0, 12);
    checks++;
    if (armed !== 1'b1) begin errors++; $display("[TB] FAIL mid_rearm: armed=%b required 1", armed); end
    check_drained("midload");
  endtask

  initial begin
    test_reset;
    test_load_arm;
    test_datapath;
    test_sample_gating;
    test_restart;
    test_lockout;
    test_midload_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_keygate_array.md
LOCK_KEYGATE_ARRAY -- requirements
Module: lock_keygate_array

Interface
REQ-001 SHALL have parameter DATA_W, default 8: number of XOR key-gated data bits.
REQ-002 SHALL have parameter LUT_N, default 1: number of 4:1 mux key-gates.
REQ-003 SHALL have parameter MAX_RELOAD, default 3: key_start pulses accepted before permanent lockout.
REQ-004 SHALL have derived localparam KEY_W = DATA_W + 4*LUT_N.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 key_start  in  1  begin (re)load of key; clears key register.
REQ-008 key_valid  in  1  key_bit qualifier.
REQ-009 key_bit  in  1  serial key bit, first bit ends up at key[KEY_W-1].
REQ-010 in_valid  in  1  data qualifier.
REQ-011 in_data  in  DATA_W  data to XOR key-gate.
REQ-012 in_lut_a  in  LUT_N  mux-gate select, low bit of index.
REQ-013 in_lut_b  in  LUT_N  mux-gate select, high bit of index.
REQ-014 out_valid  out  1  registered output qualifier.
REQ-015 out_data  out  DATA_W  registered keyed data.
REQ-016 out_lut  out  LUT_N  registered mux-gate outputs.
REQ-017 armed  out  1  key complete, datapath live.
REQ-018 key_ready  out  1  high in EMPTY or LOADING.
REQ-019 locked_out  out  1  permanent lockout flag.

Function
REQ-020 FSM states SHALL be EMPTY, LOADING, ARMED, LOCKOUT; armed = (state==ARMED), locked_out = (state==LOCKOUT).
REQ-021 key_start SHALL be accepted when load_cnt < MAX_RELOAD: key <= 0, bit_cnt <= 0, load_cnt++, state -> LOADING; from any state except LOCKOUT.
REQ-022 key_start with load_cnt == MAX_RELOAD SHALL move state to LOCKOUT; key register cleared.
REQ-023 In LOADING, key_valid without key_start SHALL shift key <= {key[KEY_W-2:0], key_bit} and increment bit_cnt.
REQ-024 When the KEY_W-th bit is shifted, state SHALL become ARMED on that same edge.
REQ-025 key_start and key_valid in the same cycle: key_start wins, bit discarded.
REQ-026 key_valid in EMPTY, ARMED or LOCKOUT SHALL be ignored.
REQ-027 Key layout: key[DATA_W-1:0] XOR bits; key[DATA_W+4j+3:DATA_W+4j] entries p[3:0] of mux-gate j.
REQ-028 Data SHALL be sampled when in_valid && state==ARMED && !key_start; latency exactly 1 cycle.
REQ-029 out_data SHALL be in_data XOR key[DATA_W-1:0], registered.
REQ-030 out_lut[j] SHALL equal p_j[2*in_lut_b[j] + in_lut_a[j]], registered.
REQ-031 out_valid SHALL be 1 only the cycle after a sample; otherwise 0; out_data/out_lut hold last values when out_valid is 0.
REQ-032 In LOCKOUT all inputs SHALL be ignored until rst_n asserted; out_valid 0.

Reset
REQ-033 rst_n low SHALL immediately force: state EMPTY, key 0, bit_cnt 0, load_cnt 0, out_valid 0, out_data 0, out_lut 0.
REQ-034 Reset values observable: armed 0, key_ready 1, locked_out 0.
REQ-035 Reset asserted mid-load SHALL discard partial key; no reload credit retained.

Verification (DATA_W=8, LUT_N=1, KEY_W=12, MAX_RELOAD=3)
REQ-036 key_start, then 12 bits of 12'hA5C MSB first -> armed 1 the cycle after last bit; key_ready 0.
REQ-037 Armed with 12'hA5C, in_data 8'hFF, a=1 b=0 -> next cycle out_valid 1, out_data 8'hA3, out_lut 1; a=0 b=0 -> out_lut 0.
REQ-038 in_valid before arming or in same cycle as key_start in ARMED -> out_valid stays 0.
REQ-039 Load 5 bits, key_start with key_valid same cycle, then 12 bits of 12'h000 -> armed, in_data 8'h3C -> out_data 8'h3C.
REQ-040 Four key_start pulses -> after 4th, locked_out 1, armed 0; further key_start/in_valid no effect until rst_n low.
REQ-041 rst_n low mid-load (bit 7) -> all outputs at reset values asynchronously, key_ready 1, reload count restored to 0.
